// File: rtl/morse_keyer_ctrl.sv
// morse_keyer_ctrl
// Accepts ASCII characters on a valid/ready handshake, looks each one up in
// an external registered ASCII-to-Morse convertor (1-cycle latency), then
// keys the Morse pattern with standard unit timing.
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   in_ascii      character to send            (with in_valid / in_ready)
//   abort         cancel the character in flight (ignored when idle)
//   conv_ascii    address to the convertor; holds the last accepted char
//   conv_morse    convertor pattern, bit i = element i (1 = dash), bit 7 unused
//   conv_len      convertor element count, 0 = word space
//   key_out       registered key, high = tone
//   busy          not idle
//   char_done     one-cycle pulse after a character and its trailing gap
//   drop          one-cycle pulse when an out-of-range code is rejected
module morse_keyer_ctrl #(
  parameter int unsigned UNIT_CYCLES = 2160000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_ascii,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] conv_ascii,
  input  logic [7:0] conv_morse,
  input  logic [2:0] conv_len,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_LATCH, S_MARK, S_ELEM_GAP, S_CHAR_GAP, S_WORD_GAP, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(UNIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic [6:0]       pat_q, pat_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [1:0]       unit_q, unit_d;
  logic             key_q, key_d;
  logic             drop_q, drop_d;

  logic       unit_end;
  logic [1:0] units_m1;
  logic       last_unit;
  logic       unused_msb;

  assign unused_msb = conv_morse[7];

  // Duration of the current timed state, in units minus one.
  always_comb begin
    units_m1 = 2'd0;
    case (state_q)
      S_MARK:     units_m1 = pat_q[idx_q] ? 2'd2 : 2'd0;
      S_CHAR_GAP: units_m1 = 2'd2;
      S_WORD_GAP: units_m1 = 2'd3;
      default:    units_m1 = 2'd0;
    endcase
  end

  assign unit_end  = (tick_q == TICK_LAST);
  assign last_unit = unit_end && (unit_q == units_m1);

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    key_d   = key_q;
    drop_d  = 1'b0;
    tick_d  = unit_end ? '0 : tick_q + 1'b1;
    unit_d  = unit_end ? unit_q + 2'd1 : unit_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_ascii >= 8'd32 && in_ascii <= 8'd122) begin
            char_d  = in_ascii;
            state_d = S_LOOKUP;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_LOOKUP: state_d = S_LATCH;
      S_LATCH: begin
        pat_d = conv_morse[6:0];
        idx_d = conv_len - 3'd1;
        if (conv_len == 3'd0) begin
          state_d = S_WORD_GAP;
        end else begin
          state_d = S_MARK;
          key_d   = 1'b1;
        end
      end
      S_MARK: begin
        if (last_unit) begin
          key_d   = 1'b0;
          state_d = (idx_q == 3'd0) ? S_CHAR_GAP : S_ELEM_GAP;
        end
      end
      S_ELEM_GAP: begin
        if (last_unit) begin
          idx_d   = idx_q - 3'd1;
          state_d = S_MARK;
          key_d   = 1'b1;
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (last_unit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      key_d   = 1'b0;
    end

    // Restart unit timing on every state entry so durations never carry over.
    if (state_d != state_q) begin
      tick_d = '0;
      unit_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      char_q  <= 8'h20;
      pat_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      unit_q  <= '0;
      key_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      key_q   <= key_d;
      drop_q  <= drop_d;
    end
  end

  assign key_out    = key_q;
  assign conv_ascii = char_q;
  assign drop       = drop_q;
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign char_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Bench for morse_keyer_ctrl with UNIT_CYCLES=4 and a small registered
// convertor model. Cycle index k counts negedge samples after the accept edge
// (k=0 is the cycle right after it); "done_at" is k+1 of the char_done cycle.
module tb_morse_keyer_ctrl;

  logic       clk, rst;
  logic [7:0] in_ascii;
  logic       in_valid, in_ready, abort;
  logic [7:0] conv_ascii, conv_morse;
  logic [2:0] conv_len;
  logic       key_out, busy, char_done, drop;

  int errors = 0;
  int checks = 0;

  morse_keyer_ctrl #(.UNIT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_ascii(in_ascii), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .conv_ascii(conv_ascii),
    .conv_morse(conv_morse), .conv_len(conv_len), .key_out(key_out),
    .busy(busy), .char_done(char_done), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Convertor model: {len, pattern}; pattern bit len-1 is sent first.
  function automatic logic [10:0] lut(input logic [7:0] a);
    case (a)
      8'h45:   lut = {3'd1, 8'h80};  // E .   (bit 7 set: must be ignored)
      8'h41:   lut = {3'd2, 8'h01};  // A .-
      8'h42:   lut = {3'd4, 8'h08};  // B -...
      8'h53:   lut = {3'd3, 8'h00};  // S ...
      8'h54:   lut = {3'd1, 8'h01};  // T -
      8'h30:   lut = {3'd5, 8'h1F};  // 0 -----
      8'h24:   lut = {3'd7, 8'h09};  // $ ...-..-
      default: lut = {3'd0, 8'h00};
    endcase
  endfunction

  always_ff @(posedge clk) {conv_len, conv_morse} <= lut(conv_ascii);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       exp_drop;
    int         exp_done;
    int         exp_high;
    int         exp_marks;
  } vec_t;

  vec_t vecs[13];

  // Measurements of the last run_char call.
  int m_done_at, m_high, m_marks, m_rise, m_drops, m_dones, m_busy, m_notready;
  int m_ready_after, m_conv0;

  task automatic run_char(input logic [7:0] ch);
    int t;
    logic prev;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    chk("ready_wait", int'(in_ready), 1);
    in_ascii = ch; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    m_done_at = -1; m_high = 0; m_marks = 0; m_rise = -1; m_drops = 0;
    m_dones = 0; m_busy = 0; m_notready = 0; m_ready_after = -1; prev = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) m_conv0 = int'(conv_ascii);
      if (key_out) m_high++;
      if (key_out && !prev) begin m_marks++; if (m_rise < 0) m_rise = k; end
      prev = key_out;
      if (drop) m_drops++;
      if (busy) m_busy++;
      if (!in_ready) m_notready++;
      if (k == m_done_at) m_ready_after = int'(in_ready);
      if (char_done) begin m_dones++; if (m_done_at < 0) m_done_at = k + 1; end
    end
  endtask

  int last_acc;
  int runs[$];
  int exp_runs[13] = '{2, 4, 4, 12, 16, 12, 4, 4, 4, 4, 4, 4, 13};

  initial begin
    int k, cur, rises, a_done, b_acc, b_done, first_lvl, bad;
    logic prevv;
    rst = 1'b0; in_ascii = 8'h00; in_valid = 1'b0; abort = 1'b0;

    vecs[0]  = '{8'h7E, 1'b1,  0,  0, 0};
    vecs[1]  = '{8'h45, 1'b0, 19,  4, 1};
    vecs[2]  = '{8'h0A, 1'b1,  0,  0, 0};
    vecs[3]  = '{8'h41, 1'b0, 35, 16, 2};
    vecs[4]  = '{8'h42, 1'b0, 51, 24, 4};
    vecs[5]  = '{8'h53, 1'b0, 35, 12, 3};
    vecs[6]  = '{8'h54, 1'b0, 27, 12, 1};
    vecs[7]  = '{8'h30, 1'b0, 91, 60, 5};
    vecs[8]  = '{8'h24, 1'b0, 83, 44, 7};
    vecs[9]  = '{8'h20, 1'b0, 19,  0, 0};
    vecs[10] = '{8'h7A, 1'b0, 19,  0, 0};
    vecs[11] = '{8'h7B, 1'b1,  0,  0, 0};
    vecs[12] = '{8'h1F, 1'b1,  0,  0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_key", int'(key_out), 0);
    chk("rst_done", int'(char_done), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_conv", int'(conv_ascii), 32'h20);
    rst = 1'b1;
    @(negedge clk);

    // abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", int'(in_ready), 1);
    chk("idle_abort_busy", int'(busy), 0);

    last_acc = 32'h20;
    for (int i = 0; i < 13; i++) begin
      run_char(vecs[i].ch);
      if (vecs[i].exp_drop) begin
        chk($sformatf("v%0d_drops", i), m_drops, 1);
        chk($sformatf("v%0d_dones", i), m_dones, 0);
        chk($sformatf("v%0d_high", i), m_high, 0);
        chk($sformatf("v%0d_busy", i), m_busy, 0);
        chk($sformatf("v%0d_notready", i), m_notready, 0);
        chk($sformatf("v%0d_conv", i), m_conv0, last_acc);
      end else begin
        chk($sformatf("v%0d_done_at", i), m_done_at, vecs[i].exp_done);
        chk($sformatf("v%0d_dones", i), m_dones, 1);
        chk($sformatf("v%0d_high", i), m_high, vecs[i].exp_high);
        chk($sformatf("v%0d_marks", i), m_marks, vecs[i].exp_marks);
        chk($sformatf("v%0d_rise", i), m_rise, (vecs[i].exp_marks > 0) ? 2 : -1);
        chk($sformatf("v%0d_drops", i), m_drops, 0);
        chk($sformatf("v%0d_busy", i), m_busy, vecs[i].exp_done);
        chk($sformatf("v%0d_ready_after", i), m_ready_after, 1);
        chk($sformatf("v%0d_conv", i), m_conv0, int'(vecs[i].ch));
        last_acc = int'(vecs[i].ch);
      end
    end

    // Back-to-back A then B with in_valid held
    @(negedge clk);
    in_ascii = 8'h41; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_ascii = 8'h42;
    a_done = -1; b_acc = -1; b_done = -1; cur = 0; prevv = 1'b0; first_lvl = 0;
    runs.delete();
    for (k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin prevv = key_out; cur = 1; first_lvl = int'(key_out); end
      else if (key_out == prevv) cur++;
      else begin runs.push_back(cur); cur = 1; prevv = key_out; end
      if (k == b_acc) in_valid = 1'b0;
      if (in_valid && in_ready && b_acc < 0) b_acc = k + 1;
      if (char_done) begin
        if (a_done < 0) a_done = k;
        else begin b_done = k; break; end
      end
    end
    in_valid = 1'b0;
    runs.push_back(cur);
    chk("b2b_first_lvl", first_lvl, 0);
    chk("b2b_a_done", a_done, 34);
    chk("b2b_b_accept", b_acc, 36);
    chk("b2b_b_done", b_done, 86);
    chk("b2b_nruns", runs.size(), 13);
    for (int i = 0; i < 13 && i < runs.size(); i++)
      chk($sformatf("b2b_run%0d", i), runs[i], exp_runs[i]);

    // '$' with abort during the third mark, then 'T'
    repeat (2) @(negedge clk);
    in_ascii = 8'h24; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rises = 0; prevv = 1'b0; k = 0;
    while (k < 100) begin
      if (key_out && !prevv) rises++;
      prevv = key_out;
      if (rises == 3) break;
      @(negedge clk); k++;
    end
    chk("abort_third_rise_k", k, 18);
    @(negedge clk);
    chk("abort_key_before", int'(key_out), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_key", int'(key_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(in_ready), 1);
    @(negedge clk);
    abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (char_done || key_out) bad++;
    end
    chk("abort_quiet", bad, 0);
    run_char(8'h54);
    chk("post_abort_T_high", m_high, 12);
    chk("post_abort_T_done", m_done_at, 27);

    // Reset mid-dash: key drops before any clock edge
    @(negedge clk);
    in_ascii = 8'h42; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_key_before", int'(key_out), 1);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_key", int'(key_out), 0);
    chk("rstmid_ready", int'(in_ready), 1);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_conv", int'(conv_ascii), 32'h20);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstrel_ready", int'(in_ready), 1);
    chk("rstrel_key", int'(key_out), 0);
    chk("rstrel_conv", int'(conv_ascii), 32'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
